// File: rtl/radio_seq_pkg.sv
// rtl/radio_seq_pkg.sv - shared state encoding and default timing constants for the radio power sequencer
package radio_seq_pkg;

    localparam int DEFAULT_SETTLE_CYCLES = 16;
    localparam int DEFAULT_PLL_TIMEOUT   = 1024;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_PLL_WAIT = 3'd1,
        ST_ISO_REL  = 3'd2,
        ST_RADIO_ON = 3'd3,
        ST_RX_ON    = 3'd4,
        ST_SHUTDOWN = 3'd5
`ifdef RADIO_SEQ_TIMEOUT_EN
        ,
        ST_ERROR    = 3'd6
`endif
    } seq_state_t;

endpackage

// File: rtl/radio_seq_ctrl_if.sv
// rtl/radio_seq_ctrl_if.sv - request/status bundle between the radio sequencer and its host
interface radio_seq_ctrl_if;

    logic       radioReq;
    logic       rxReq;
    logic       pllSettled;
    logic       pllEn;
    logic       isolate;
    logic       radioEnable;
    logic       radioRxEn;
    logic       seqErr;
    logic [2:0] seqState;

    modport master (
        output radioReq, rxReq, pllSettled,
        input  pllEn, isolate, radioEnable, radioRxEn, seqErr, seqState
    );

    modport slave (
        input  radioReq, rxReq, pllSettled,
        output pllEn, isolate, radioEnable, radioRxEn, seqErr, seqState
    );

endinterface

// File: rtl/radio_seq_ctrl_seq_timer.sv
// rtl/radio_seq_ctrl_seq_timer.sv - loadable down-counter that stops at zero and flags done there
module seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             arst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/radio_seq_ctrl.sv
// rtl/radio_seq_ctrl.sv - radio power-up/down sequencer (PLL, isolation, enables)
// Optional PLL lock timeout and ERROR state: define RADIO_SEQ_TIMEOUT_EN.
module radio_seq_ctrl
    import radio_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int PLL_TIMEOUT   = DEFAULT_PLL_TIMEOUT
) (
    input  logic             ck,
    input  logic             arst,
    radio_seq_ctrl_if.slave  bus
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    // An illegal parameter set leaves this marker scope in the elaborated hierarchy.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
        PLL_TIMEOUT < 2 || PLL_TIMEOUT > 65535) begin : g_param_out_of_range
    end

    seq_state_t state;
    seq_state_t next_state;
    logic       set_err;
    logic       settle_done;
    logic       nx_pll_en;
    logic       nx_isolate;
    logic       nx_radio_en;
    logic       nx_rx_en;

    // Counts load on the cycle the FSM enters the timed state, so the first
    // cycle spent in that state already sees the full count.
    seq_timer #(.WIDTH(SW)) u_settle (
        .ck       (ck),
        .arst     (arst),
        .load     ((next_state == ST_ISO_REL) && (state != ST_ISO_REL)),
        .load_val (SETTLE_LOAD),
        .en       (state == ST_ISO_REL),
        .done     (settle_done)
    );

`ifdef RADIO_SEQ_TIMEOUT_EN
    logic timeout_done;

    seq_timer #(.WIDTH(16)) u_timeout (
        .ck       (ck),
        .arst     (arst),
        .load     ((next_state == ST_PLL_WAIT) && (state != ST_PLL_WAIT)),
        .load_val (16'(PLL_TIMEOUT - 1)),
        .en       (state == ST_PLL_WAIT),
        .done     (timeout_done)
    );
`endif

    always_comb begin
        next_state = state;
        set_err    = 1'b0;
        case (state)
            ST_OFF: begin
                if (bus.radioReq) next_state = ST_PLL_WAIT;
            end
            ST_PLL_WAIT: begin
                if (!bus.radioReq)        next_state = ST_SHUTDOWN;
                else if (bus.pllSettled)  next_state = ST_ISO_REL;
`ifdef RADIO_SEQ_TIMEOUT_EN
                else if (timeout_done) begin
                    next_state = ST_ERROR;
                    set_err    = 1'b1;
                end
`endif
            end
            ST_ISO_REL, ST_RADIO_ON, ST_RX_ON: begin
                // Losing lock is an error even when the request drops in the same cycle.
                set_err = !bus.pllSettled;
                if (!bus.radioReq || !bus.pllSettled) begin
                    next_state = ST_SHUTDOWN;
                end else if (state == ST_ISO_REL) begin
                    if (settle_done) next_state = ST_RADIO_ON;
                end else if (state == ST_RADIO_ON) begin
                    if (bus.rxReq) next_state = ST_RX_ON;
                end else begin
                    if (!bus.rxReq) next_state = ST_RADIO_ON;
                end
            end
            ST_SHUTDOWN: begin
                next_state = ST_OFF;
            end
`ifdef RADIO_SEQ_TIMEOUT_EN
            ST_ERROR: begin
                if (!bus.radioReq) next_state = ST_OFF;
            end
`endif
            default: begin
                next_state = ST_OFF;
            end
        endcase
    end

    // Outputs are registered from the decode of the state being entered.
    always_comb begin
        nx_pll_en   = 1'b0;
        nx_isolate  = 1'b1;
        nx_radio_en = 1'b0;
        nx_rx_en    = 1'b0;
        case (next_state)
            ST_PLL_WAIT, ST_SHUTDOWN: begin
                nx_pll_en = 1'b1;
            end
            ST_ISO_REL: begin
                nx_pll_en  = 1'b1;
                nx_isolate = 1'b0;
            end
            ST_RADIO_ON: begin
                nx_pll_en   = 1'b1;
                nx_isolate  = 1'b0;
                nx_radio_en = 1'b1;
            end
            ST_RX_ON: begin
                nx_pll_en   = 1'b1;
                nx_isolate  = 1'b0;
                nx_radio_en = 1'b1;
                nx_rx_en    = 1'b1;
            end
            default: begin
                nx_pll_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            state           <= ST_OFF;
            bus.pllEn       <= 1'b0;
            bus.isolate     <= 1'b1;
            bus.radioEnable <= 1'b0;
            bus.radioRxEn   <= 1'b0;
            bus.seqErr      <= 1'b0;
        end else begin
            state           <= next_state;
            bus.pllEn       <= nx_pll_en;
            bus.isolate     <= nx_isolate;
            bus.radioEnable <= nx_radio_en;
            bus.radioRxEn   <= nx_rx_en;
            if (set_err) begin
                bus.seqErr <= 1'b1;
            end else if ((state == ST_OFF) && !bus.radioReq) begin
                bus.seqErr <= 1'b0;
            end
        end
    end

    assign bus.seqState = state;

endmodule
